// File: rtl/fetch_ctrl_mv.sv
// ============================================================================
// Module   : fetch_ctrl_mv
// Brief    : Fetch-stage PC control FSM with N prioritised interrupts,
//            multi-word fetch, RET/RTI wait and stall_in freeze.
//            Optional per-line interrupt mask via FETCH_IRQ_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl_mv #(
    parameter  int N_IRQ     = 4,
    parameter  int EXT_WORDS = 1,
    parameter  int RET_WAIT  = 2,
    localparam int AS_W      = $clog2(N_IRQ + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_req,
`ifdef FETCH_IRQ_MASK_EN
    input  logic [N_IRQ-1:0] irq_mask,
`endif
    input  logic             stall_in,
    input  logic [3:0]       opcode,
    input  logic [1:0]       brx,
    input  logic             branch_taken,
    input  logic             bypass_done,
    output logic             pc_en,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic [AS_W-1:0]  addr_src,
    output logic             stall,
    output logic             sf1,
    output logic [N_IRQ-1:0] irq_ack
);

    localparam int IDX_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int EXT_W  = (EXT_WORDS > 1) ? $clog2(EXT_WORDS) : 1;
    localparam int WAIT_W = $clog2(RET_WAIT + 1);

    localparam logic [EXT_W-1:0]  EXT_LAST  = EXT_W'(EXT_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RET_WAIT);
    localparam logic [3:0]        OP_EXT    = 4'd12;
    localparam logic [3:0]        OP_BR     = 4'd11;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_FETCHX = 3'd2,
        S_WAIT   = 3'd3,
        S_BRANCH = 3'd4,
        S_IRQ    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [EXT_W-1:0]   ext_cnt_q, ext_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]   irq_idx_q, irq_idx_d;
    logic               pc_loaded_q;

    logic [N_IRQ-1:0]   irq_en;
    logic [IDX_W-1:0]   irq_low;
    logic               is_ret;
    logic               is_jmp;

`ifdef FETCH_IRQ_MASK_EN
    assign irq_en = irq_req & ~irq_mask;
`else
    assign irq_en = irq_req;
`endif

    assign is_ret = (opcode == OP_BR) && (brx >= 2'd2);
    assign is_jmp = (opcode == OP_BR) && (brx <  2'd2);

    // Bit 0 is highest priority: scan downward so the lowest set bit wins.
    always_comb begin
        irq_low = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_en[i]) begin
                irq_low = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ext_cnt_d  = ext_cnt_q;
        wait_cnt_d = wait_cnt_q;
        irq_idx_d  = irq_idx_q;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 2'b00;
        addr_src   = '0;
        stall      = 1'b0;
        sf1        = 1'b0;
        irq_ack    = '0;

        case (state_q)
            S_RST: begin
                pc_en    = 1'b1;
                pc_load  = 1'b1;
                pc_src   = 2'b01;
                addr_src = AS_W'(1);
                state_d  = S_FETCH;
            end

            S_FETCH: begin
                pc_en = !pc_loaded_q && !stall_in;
                if (!stall_in) begin
                    if (opcode == OP_EXT) begin
                        state_d   = S_FETCHX;
                        ext_cnt_d = '0;
                    end else if (branch_taken || is_jmp) begin
                        state_d = S_BRANCH;
                    end else if (is_ret) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end else if (|irq_en) begin
                        state_d   = S_IRQ;
                        irq_idx_d = irq_low;
                    end
                end
            end

            S_FETCHX: begin
                pc_en = !stall_in;
                if (!stall_in) begin
                    if (ext_cnt_q == EXT_LAST) begin
                        ext_cnt_d = '0;
                        state_d   = S_FETCH;
                    end else begin
                        ext_cnt_d = ext_cnt_q + 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_BRANCH;
                end else begin
                    stall = 1'b1;
                    if (!stall_in) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            S_BRANCH: begin
                if (branch_taken) begin
                    pc_src = 2'b00;
                    pc_en  = 1'b1;
                end else if (is_ret) begin
                    pc_src = 2'b11;
                    pc_en  = 1'b1;
                end else if (bypass_done) begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end else begin
                    stall = 1'b1;
                end
                pc_load = pc_en;
                if (pc_en) begin
                    state_d = S_FETCH;
                end
            end

            S_IRQ: begin
                pc_en              = 1'b1;
                pc_load            = 1'b1;
                pc_src             = 2'b01;
                addr_src           = AS_W'(2) + AS_W'(irq_idx_q);
                sf1                = 1'b1;
                irq_ack[irq_idx_q] = 1'b1;
                state_d            = S_FETCH;
            end

            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RST;
            ext_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            irq_idx_q   <= '0;
            pc_loaded_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ext_cnt_q   <= ext_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            irq_idx_q   <= irq_idx_d;
            // Remembers a load so the first FETCH cycle after it does not increment.
            pc_loaded_q <= pc_en && pc_load;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl_mv.sv
// ============================================================================
// Module   : tb_fetch_ctrl_mv
// Brief    : Directed self-checking bench for fetch_ctrl_mv
//            (N_IRQ=4, EXT_WORDS=2, RET_WAIT=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl_mv;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_req;
`ifdef FETCH_IRQ_MASK_EN
    logic [3:0] irq_mask;
`endif
    logic       stall_in;
    logic [3:0] opcode;
    logic [1:0] brx;
    logic       branch_taken;
    logic       bypass_done;
    logic       pc_en;
    logic       pc_load;
    logic [1:0] pc_src;
    logic [2:0] addr_src;
    logic       stall;
    logic       sf1;
    logic [3:0] irq_ack;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    fetch_ctrl_mv #(
        .N_IRQ     (4),
        .EXT_WORDS (2),
        .RET_WAIT  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
`ifdef FETCH_IRQ_MASK_EN
        .irq_mask     (irq_mask),
`endif
        .stall_in     (stall_in),
        .opcode       (opcode),
        .brx          (brx),
        .branch_taken (branch_taken),
        .bypass_done  (bypass_done),
        .pc_en        (pc_en),
        .pc_load      (pc_load),
        .pc_src       (pc_src),
        .addr_src     (addr_src),
        .stall        (stall),
        .sf1          (sf1),
        .irq_ack      (irq_ack)
    );

    // Packed view {pc_en, pc_load, pc_src, addr_src, stall, sf1, irq_ack}
    logic [12:0] obs;
    assign obs = {pc_en, pc_load, pc_src, addr_src, stall, sf1, irq_ack};

    function automatic logic [12:0] ev(input logic en, input logic ld, input logic [1:0] src,
                                       input logic [2:0] as, input logic st, input logic sf,
                                       input logic [3:0] ack);
        return {en, ld, src, as, st, sf, ack};
    endfunction

    localparam logic [12:0] E_IDLE  = 13'd0;
    localparam logic [12:0] E_FEN   = {1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 4'b0000};
    localparam logic [12:0] E_STALL = {1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 4'b0000};
    localparam logic [12:0] E_RST   = {1'b1, 1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 4'b0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] exp);
        #1;
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        irq_req      = 4'b0000;
`ifdef FETCH_IRQ_MASK_EN
        irq_mask     = 4'b0000;
`endif
        stall_in     = 1'b0;
        opcode       = 4'd0;
        brx          = 2'd0;
        branch_taken = 1'b0;
        bypass_done  = 1'b1;

        // Reset vector fetch, then redundant-increment suppression
        tick(); tick();
        chk("rst_hold", E_RST);
        reset = 1'b0;
        chk("rst_release", E_RST);
        tick(); chk("fetch_first", E_IDLE);
        tick(); chk("fetch_incr", E_FEN);

        // Two extra words with one stalled cycle in FETCHX
        opcode = 4'd12;
        chk("fx_decode", E_FEN);
        tick(); opcode = 4'd0; stall_in = 1'b1;
        chk("fx_stalled", E_IDLE);
        tick(); stall_in = 1'b0;
        chk("fx_word1", E_FEN);
        tick(); chk("fx_word2", E_FEN);
        tick(); chk("fx_back_fetch", E_FEN);

        // stall_in in FETCH defers a pending interrupt
        stall_in = 1'b1; irq_req = 4'b0001;
        chk("fetch_stall", E_IDLE);
        tick(); chk("fetch_stall_hold", E_IDLE);
        stall_in = 1'b0;
        chk("fetch_unstall", E_FEN);
        tick(); chk("irq0_after_stall", ev(1, 1, 2'b01, 3'd2, 0, 1, 4'b0001));
        irq_req = 4'b0000;
        tick(); chk("irq0_ret_fetch", E_IDLE);
        tick(); chk("irq0_fetch_incr", E_FEN);

        // RET with one stall_in cycle during WAIT
        opcode = 4'd11; brx = 2'd2;
        chk("ret_decode", E_FEN);
        tick(); stall_in = 1'b1;
        chk("ret_wait_frozen", E_STALL);
        tick(); stall_in = 1'b0;
        chk("ret_wait_c0", E_STALL);
        tick(); chk("ret_wait_c1", E_STALL);
        tick(); chk("ret_wait_end", E_IDLE);
        tick(); chk("ret_load", ev(1, 1, 2'b11, 3'd0, 0, 0, 4'b0000));
        tick(); opcode = 4'd0; brx = 2'd0;
        chk("ret_fetch", E_IDLE);
        tick(); chk("ret_fetch_incr", E_FEN);

        // JMP waiting two cycles on bypass
        opcode = 4'd11; brx = 2'd0; bypass_done = 1'b0;
        chk("jmp_decode", E_FEN);
        tick(); chk("jmp_bypass_wait0", E_STALL);
        tick(); chk("jmp_bypass_wait1", E_STALL);
        bypass_done = 1'b1;
        chk("jmp_load", ev(1, 1, 2'b10, 3'd0, 0, 0, 4'b0000));
        tick(); opcode = 4'd0;
        chk("jmp_fetch", E_IDLE);
        tick(); chk("jmp_fetch_incr", E_FEN);

        // Taken branch beats an interrupt in the same cycle
        branch_taken = 1'b1; irq_req = 4'b0001;
        chk("bt_decode", E_FEN);
        tick(); chk("bt_load", ev(1, 1, 2'b00, 3'd0, 0, 0, 4'b0000));
        tick(); branch_taken = 1'b0;
        chk("bt_fetch_no_ack", E_IDLE);
        tick(); chk("bt_then_irq0", ev(1, 1, 2'b01, 3'd2, 0, 1, 4'b0001));
        irq_req = 4'b0000;
        tick(); chk("bt_irq_fetch", E_IDLE);

        // Two simultaneous requests serviced in priority order
        irq_req = 4'b0101;
        tick(); chk("irq_pri_k0", ev(1, 1, 2'b01, 3'd2, 0, 1, 4'b0001));
        irq_req = 4'b0100;
        tick(); chk("irq_pri_fetch", E_IDLE);
        tick(); chk("irq_pri_k2", ev(1, 1, 2'b01, 3'd4, 0, 1, 4'b0100));
        irq_req = 4'b0000;
        tick(); chk("irq_pri_done", E_IDLE);
        tick(); chk("irq_pri_incr", E_FEN);

        // Interrupt raised during RTI WAIT is held until the FETCH boundary
        opcode = 4'd11; brx = 2'd3;
        chk("rti_decode", E_FEN);
        tick(); irq_req = 4'b0010;
        chk("rti_wait_c0", E_STALL);
        tick(); chk("rti_wait_c1", E_STALL);
        tick(); chk("rti_wait_end", E_IDLE);
        tick(); chk("rti_load_no_ack", ev(1, 1, 2'b11, 3'd0, 0, 0, 4'b0000));
        tick(); opcode = 4'd0; brx = 2'd0;
        chk("rti_fetch_no_ack", E_IDLE);
        tick(); chk("rti_then_irq1", ev(1, 1, 2'b01, 3'd3, 0, 1, 4'b0010));
        irq_req = 4'b0000;
        tick(); chk("rti_irq_fetch", E_IDLE);

        // Reset mid-WAIT with a pending request: back to RST, no ack
        opcode = 4'd11; brx = 2'd2; irq_req = 4'b0001;
        tick(); chk("mid_wait", E_STALL);
        reset = 1'b1;
        tick(); chk("mid_reset_rst", E_RST);
        reset = 1'b0; opcode = 4'd0; brx = 2'd0; irq_req = 4'b0000;
        tick(); chk("mid_reset_fetch", E_IDLE);
        tick(); chk("mid_reset_incr", E_FEN);

`ifdef FETCH_IRQ_MASK_EN
        // Masked line stays pending and is never acknowledged
        irq_mask = 4'b0010; irq_req = 4'b0010;
        tick(); chk("mask_hold0", E_FEN);
        tick(); chk("mask_hold1", E_FEN);
        irq_req = 4'b0011;
        tick(); chk("mask_other_line", ev(1, 1, 2'b01, 3'd2, 0, 1, 4'b0001));
        irq_req = 4'b0000; irq_mask = 4'b0000;
        tick(); chk("mask_done", E_IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
